mash11_modulator: RTL



---
 rtl/mash_pkg.sv | 19 +
 rtl/mash_accum.sv | 29 ++
 rtl/mash11_modulator.sv | 120 ++++++++++++
 3 files changed

// File: rtl/mash_pkg.sv
// Shared types and constants for the MASH 1-1 delta-sigma modulator.
package mash_pkg;

    localparam int unsigned DATA_WIDTH_DEFAULT = 16;
    localparam int unsigned CLK_DIV_DEFAULT    = 4;

    typedef logic [DATA_WIDTH_DEFAULT-1:0] sample_t;
    typedef logic [1:0]                    dac_code_t;

    // Code for signed level 0 (code = level + 1).
    localparam dac_code_t DAC_CODE_ZERO = 2'd1;

    // Combine the two stage carries into the offset output code:
    // y = c1 + c2 - c2_d in -1..+2, returned as y + 1 in 0..3.
    function automatic dac_code_t level_to_code(input logic c1, input logic c2, input logic c2_d);
        return dac_code_t'(2'd1 + {1'b0, c1} + {1'b0, c2} - {1'b0, c2_d});
    endfunction

endpackage

// File: rtl/mash_accum.sv
// One first-order error-feedback stage: accumulator with carry-out.
module mash_accum #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  aclk,
    input  logic                  arst_n,
    input  logic                  i_tick,
    input  logic [DATA_WIDTH-1:0] i_in,
    output logic [DATA_WIDTH-1:0] o_residue_c,
    output logic                  o_carry_c
);

    logic [DATA_WIDTH-1:0] r_acc;
    logic [DATA_WIDTH:0]   w_sum;

    assign w_sum       = {1'b0, r_acc} + {1'b0, i_in};
    assign o_residue_c = w_sum[DATA_WIDTH-1:0];
    assign o_carry_c   = w_sum[DATA_WIDTH];

    // Commit the new residue on each modulator tick; wraps modulo 2^DATA_WIDTH.
    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            r_acc <= '0;
        end else if (i_tick) begin
            r_acc <= w_sum[DATA_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/mash11_modulator.sv
// Second-order MASH 1-1 modulator: AXI-stream sample in, 2-bit DAC code out.
module mash11_modulator
    import mash_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int unsigned CLK_DIV    = CLK_DIV_DEFAULT
) (
    input  logic                  aclk,
    input  logic                  arst_n,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] s_axis_data_tdata,
    input  logic                  s_axis_data_tvalid,
    output logic                  s_axis_data_tready,
    output logic [1:0]            dac_code,
    output logic                  dac_strobe,
    output logic                  underrun
);

    localparam int unsigned        CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_hold;
    logic                  r_hold_valid;
    logic                  r_tready;
    logic [DATA_WIDTH-1:0] r_x;
    logic                  r_c2_d;
    dac_code_t             r_dac_code;
    logic                  r_dac_strobe;
    logic                  r_underrun;

    logic                  w_tick;
    logic                  w_accept;
    logic [DATA_WIDTH-1:0] w_res1;
    logic [DATA_WIDTH-1:0] w_res2_unused;
    logic                  w_c1;
    logic                  w_c2;
    dac_code_t             w_code;

    assign w_tick   = enable && (r_cnt == CNT_LAST);
    assign w_accept = s_axis_data_tvalid && r_tready;
    assign w_code   = level_to_code(w_c1, w_c2, r_c2_d);

    assign s_axis_data_tready = r_tready;
    assign dac_code           = r_dac_code;
    assign dac_strobe         = r_dac_strobe;
    assign underrun           = r_underrun;

    // Stage 1 integrates the working sample captured before this tick.
    mash_accum #(.DATA_WIDTH(DATA_WIDTH)) u_stage1 (
        .aclk        (aclk),
        .arst_n      (arst_n),
        .i_tick      (w_tick),
        .i_in        (r_x),
        .o_residue_c (w_res1),
        .o_carry_c   (w_c1)
    );

    // Stage 2 integrates stage 1's freshly computed residue.
    mash_accum #(.DATA_WIDTH(DATA_WIDTH)) u_stage2 (
        .aclk        (aclk),
        .arst_n      (arst_n),
        .i_tick      (w_tick),
        .i_in        (w_res1),
        .o_residue_c (w_res2_unused),
        .o_carry_c   (w_c2)
    );

    // Tick divider: counts 0..CLK_DIV-1 while enabled, cleared while frozen.
    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            r_cnt <= '0;
        end else if (!enable || w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // One-entry holding buffer; a tick moves it into the working sample.
    // Accept and drain cannot coincide since tready is low while full.
    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
            r_tready     <= 1'b1;
            r_x          <= '0;
        end else if (w_accept) begin
            r_hold       <= s_axis_data_tdata;
            r_hold_valid <= 1'b1;
            r_tready     <= 1'b0;
        end else if (w_tick && r_hold_valid) begin
            r_x          <= r_hold;
            r_hold_valid <= 1'b0;
            r_tready     <= 1'b1;
        end
    end

    // Output code, strobe, stage-2 carry delay and sticky underrun.
    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            r_c2_d       <= 1'b0;
            r_dac_code   <= DAC_CODE_ZERO;
            r_dac_strobe <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_dac_strobe <= w_tick;
            if (w_tick) begin
                r_dac_code <= w_code;
                r_c2_d     <= w_c2;
                if (!r_hold_valid) begin
                    r_underrun <= 1'b1;
                end
            end else if (!enable) begin
                r_dac_code <= DAC_CODE_ZERO;
            end
        end
    end

endmodule
